// File: rtl/vga_capture.sv
// VGA receive-side timing decoder: rebuilds pixel coordinates, checks line/frame length, strobes locked pixels.
// Optional per-frame pixel checksum is built when VGA_CAPTURE_CHECKSUM_EN is defined.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hor_sync,
  input  logic        ver_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_red,
  output logic [7:0]  pix_green,
  output logic [7:0]  pix_blue,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic [23:0] frame_sum,
  output logic        sum_valid
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_A0   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_A1   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_A0   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_A1   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] C_MAX  = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t     state_q;
  logic       hs_prev_q, vs_prev_q, v_arm_q, started_q, bad_q;
  logic [9:0] h_cnt_q, v_cnt_q;
  logic [9:0] h_cnt_d, v_cnt_d;
  logic       hs_edge, vs_edge, arm, fs_now;
  logic       line_mis, frame_mis, h_act, v_act, valid_now;

  assign hs_edge = hs_prev_q & ~hor_sync;
  assign vs_edge = vs_prev_q & ~ver_sync;
  // A vsync edge arms first, so a coincident hsync edge closes the frame on the same sample.
  assign arm     = v_arm_q | vs_edge;
  assign fs_now  = hs_edge & arm;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_edge) h_cnt_d = '0;
    else if (h_cnt_q != C_MAX) h_cnt_d = h_cnt_q + 10'd1;
    if (fs_now) v_cnt_d = '0;
    else if (hs_edge && v_cnt_q != C_MAX) v_cnt_d = v_cnt_q + 10'd1;
  end

  // A saturated counter can never equal the expected last index, so it always reports.
  assign line_mis  = hs_edge ? (h_cnt_q != H_LAST) : (h_cnt_q == H_LAST);
  assign frame_mis = fs_now & (v_cnt_q != V_LAST);
  assign h_act     = (h_cnt_d >= H_A0) && (h_cnt_d < H_A1);
  assign v_act     = (v_cnt_d >= V_A0) && (v_cnt_d < V_A1);
  assign valid_now = (state_q == LOCKED) && h_act && v_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      v_arm_q     <= 1'b0;
      started_q   <= 1'b0;
      bad_q       <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_red     <= '0;
      pix_green   <= '0;
      pix_blue    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      if (pix_en) begin
        hs_prev_q   <= hor_sync;
        vs_prev_q   <= ver_sync;
        h_cnt_q     <= h_cnt_d;
        v_cnt_q     <= v_cnt_d;
        v_arm_q     <= arm & ~hs_edge;
        frame_start <= fs_now;
        if (valid_now) begin
          pix_valid <= 1'b1;
          pix_x     <= h_cnt_d - H_A0;
          pix_y     <= v_cnt_d - V_A0;
          pix_red   <= red;
          pix_green <= green;
          pix_blue  <= blue;
        end
        unique case (state_q)
          SEARCH: if (vs_edge) begin
            state_q   <= ALIGN;
            started_q <= fs_now;
            bad_q     <= 1'b0;
          end
          ALIGN: if (fs_now) begin
            // The first frame_start only opens the trial frame; the next one judges it.
            if (started_q && !bad_q && !line_mis && !frame_mis) begin
              state_q <= LOCKED;
              locked  <= 1'b1;
            end else begin
              started_q <= 1'b1;
              bad_q     <= 1'b0;
            end
          end else begin
            bad_q <= bad_q | line_mis;
          end
          LOCKED: begin
            line_err  <= line_mis;
            frame_err <= frame_mis;
            if (line_mis || frame_mis) begin
              state_q <= SEARCH;
              locked  <= 1'b0;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [23:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (state_q != LOCKED) begin
        acc_q <= '0;
      end else if (pix_en) begin
        if (fs_now) begin
          frame_sum <= acc_q;
          sum_valid <= 1'b1;
          acc_q     <= '0;
        end else if (valid_now) begin
          acc_q <= acc_q + {red, green, blue};
        end
      end
    end
  end
`else
  assign frame_sum = '0;
  assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced 16x11 timing so whole frames stay short.
module tb_vga_capture;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en, hor_sync, ver_sync;
  logic [7:0]  red, green, blue;
  logic        pix_valid, frame_start, locked, line_err, frame_err, sum_valid;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_red, pix_green, pix_blue;
  logic [23:0] frame_sum;

  vga_capture #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hor_sync(hor_sync), .ver_sync(ver_sync),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .frame_start(frame_start), .locked(locked), .line_err(line_err), .frame_err(frame_err),
    .frame_sum(frame_sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n_valid, n_fs, n_lerr, n_ferr, n_sv;
  int first_x, first_y, last_x, last_y;
  logic        lock_first;
  logic [23:0] sv_sum;
  logic [23:0] exp_sum;
  logic [9:0]  hold_x, hold_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_xy"}, {pix_x, pix_y}, 0);
    chk({tag, "_rgb"}, {pix_red, pix_green, pix_blue}, 0);
    chk({tag, "_pulses"}, {frame_start, line_err, frame_err, sum_valid}, 0);
    chk({tag, "_sum"}, frame_sum, 0);
  endtask

  task automatic sample(input logic hs, input logic vs, input logic [7:0] x, input logic [7:0] y,
                        input bit act, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    chk("pulse_width", {pix_valid, frame_start, line_err, frame_err, sum_valid}, 0);
    pix_en   = 1'b1;
    hor_sync = hs;
    ver_sync = vs;
    red      = x;
    green    = y;
    blue     = (x == 0 && y == 0 && !act) ? 8'h00 : 8'h5A;
    @(negedge clk);
    pix_en = 1'b0;
    if (act) begin
      chk("pix_valid", pix_valid, 1);
      chk("pix_xy", {pix_x, pix_y}, {2'b0, x, 2'b0, y});
      chk("pix_rgb", {pix_red, pix_green, pix_blue}, {x, y, 8'h5A});
      hold_x = {2'b0, x};
      hold_y = {2'b0, y};
    end else begin
      chk("pix_valid_idle", pix_valid, 0);
      chk("pix_xy_hold", {pix_x, pix_y}, {hold_x, hold_y});
    end
    if (pix_valid) begin
      if (n_valid == 0) begin
        first_x = int'(pix_x);
        first_y = int'(pix_y);
      end
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      n_valid++;
    end
    n_fs   += int'(frame_start);
    n_lerr += int'(line_err);
    n_ferr += int'(frame_err);
    if (sum_valid) begin
      n_sv++;
      sv_sum = frame_sum;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rst_mid");
    hold_x = '0;
    hold_y = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends one frame starting at its sync line; short_l shortens one line by a pixel,
  // rst_l/rst_h pulse reset just before that sample.
  task automatic frame(input int nlines, input int short_l, input int maxgap, input bit lockd,
                       input int rst_l, input int rst_h);
    bit ev;
    int len;
    bit in_act;
    ev = lockd;
    n_valid = 0; n_fs = 0; n_lerr = 0; n_ferr = 0; n_sv = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int l = 0; l < nlines; l++) begin
      if (short_l >= 0 && l == short_l + 1) ev = 0;
      len = (l == short_l) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        if (l == rst_l && h == rst_h) begin
          do_reset();
          ev = 0;
        end
        in_act = (h >= HA0) && (h < HA0 + HA) && (l >= VA0) && (l < VA0 + VA);
        sample(h >= HS, l >= VS, in_act ? 8'(h - HA0) : 8'h00, in_act ? 8'(l - VA0) : 8'h00,
               ev && in_act, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        if (l == 0 && h == 0) lock_first = locked;
      end
    end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hor_sync = 1'b1; ver_sync = 1'b1;
    red = '0; green = '0; blue = '0;
    hold_x = '0; hold_y = '0;
    exp_sum = '0;
    for (int x = 0; x < HA; x++)
      for (int y = 0; y < VA; y++)
        exp_sum = exp_sum + {8'(x), 8'(y), 8'h5A};
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    frame(VT, -1, 0, 0, -1, -1);
    chk("A_fs", n_fs, 1);
    chk("A_lock_first", lock_first, 0);
    chk("A_valid", n_valid, 0);
    chk("A_locked_end", locked, 0);

    frame(VT, -1, 0, 1, -1, -1);
    chk("B_lock_first", lock_first, 1);
    chk("B_valid", n_valid, HA * VA);
    chk("B_first", {first_x, first_y}, {32'd0, 32'd0});
    chk("B_last", {last_x, last_y}, {32'(HA - 1), 32'(VA - 1)});
    chk("B_errs", n_lerr + n_ferr, 0);

    frame(VT, -1, 5, 1, -1, -1);
    chk("C_valid", n_valid, HA * VA);
    chk("C_last", {last_x, last_y}, {32'(HA - 1), 32'(VA - 1)});
    chk("C_errs", n_lerr + n_ferr, 0);
`ifdef VGA_CAPTURE_CHECKSUM_EN
    chk("C_sum_pulses", n_sv, 1);
    chk("C_frame_sum", sv_sum, exp_sum);
`else
    chk("C_sum_pulses", n_sv, 0);
    chk("C_frame_sum", frame_sum, 0);
`endif

    frame(VT, 5, 0, 1, -1, -1);
    chk("D_line_err", n_lerr, 1);
    chk("D_valid", n_valid, 2 * HA);
    chk("D_locked_end", locked, 0);

    frame(VT, -1, 0, 0, -1, -1);
    chk("E_lock_first", lock_first, 0);
    chk("E_valid", n_valid, 0);
    chk("E_errs", n_lerr + n_ferr, 0);

    frame(VT, -1, 0, 1, -1, -1);
    chk("F_lock_first", lock_first, 1);
    chk("F_valid", n_valid, HA * VA);

    frame(VT - 1, -1, 0, 1, -1, -1);
    chk("G_valid", n_valid, HA * VA);
    chk("G_frame_err", n_ferr, 0);

    frame(VT, -1, 0, 0, -1, -1);
    chk("H_frame_err", n_ferr, 1);
    chk("H_fs", n_fs, 1);
    chk("H_lock_first", lock_first, 0);
    chk("H_valid", n_valid, 0);

    frame(VT, -1, 0, 0, -1, -1);
    chk("I_lock_first", lock_first, 0);
    chk("I_valid", n_valid, 0);

    frame(VT, -1, 0, 1, -1, -1);
    chk("J_lock_first", lock_first, 1);
    chk("J_valid", n_valid, HA * VA);

    frame(VT, -1, 0, 1, 6, 9);
    chk("K_valid", n_valid, 2 * HA + 3);
    chk("K_locked_end", locked, 0);
    chk("K_errs", n_lerr + n_ferr, 0);

    frame(VT, -1, 0, 0, -1, -1);
    chk("L_lock_first", lock_first, 0);
    chk("L_valid", n_valid, 0);

    frame(VT, -1, 2, 1, -1, -1);
    chk("M_lock_first", lock_first, 1);
    chk("M_valid", n_valid, HA * VA);
    chk("M_first", {first_x, first_y}, {32'd0, 32'd0});

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
